// File: rtl/sprinkler_pkg.sv
// rtl/sprinkler_pkg.sv - shared constants, FSM states and entry record for the sprinkler scheduler
package sprinkler_pkg;

    localparam int         MIN_PER_DAY     = 1440;
    localparam logic [7:0] ASCII_ZERO      = 8'h30;
    localparam logic [15:0] ZONE_TERMINATOR = 16'h3030;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_LO,
        ST_DECODE,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic [3:0]  zone;
        logic [10:0] start_min;
        logic [10:0] stop_min;
        logic        valid;
    } entry_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_ZERO + 8'd9);
    endfunction

    function automatic logic [3:0] digit_val(input logic [7:0] c);
        return 4'(c - ASCII_ZERO);
    endfunction

endpackage

// File: rtl/hhmm_to_min.sv
// rtl/hhmm_to_min.sv - combinational ASCII "HHMM" to minute-of-day converter with range check
module hhmm_to_min
    import sprinkler_pkg::*;
(
    input  logic [31:0] hhmm,
    output logic [10:0] minutes,
    output logic        valid
);

    logic [6:0] hh;
    logic [6:0] mm;
    logic       all_digits;

    always_comb begin
        all_digits = is_digit(hhmm[31:24]) && is_digit(hhmm[23:16]) &&
                     is_digit(hhmm[15:8])  && is_digit(hhmm[7:0]);
        hh = 7'(digit_val(hhmm[31:24])) * 7'd10 + 7'(digit_val(hhmm[23:16]));
        mm = 7'(digit_val(hhmm[15:8]))  * 7'd10 + 7'(digit_val(hhmm[7:0]));
        // minutes is meaningless when valid is low; only the range-checked case fits 0..1439
        minutes = 11'(hh) * 11'd60 + 11'(mm);
        valid   = all_digits && (hh <= 7'd23) && (mm <= 7'd59);
    end

endmodule

// File: rtl/sprinkler_scheduler.sv
// rtl/sprinkler_scheduler.sv - loads ASCII schedule lines into a table and drives per-zone valves
module sprinkler_scheduler
    import sprinkler_pkg::*;
#(
    parameter int NUM_ENTRIES    = 8,
    parameter int NUM_ZONES      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_load,
    output logic                               read_next_line,
    input  logic                               read_enable,
    input  logic [15:0]                        zone,
    input  logic [31:0]                        start_time,
    input  logic [31:0]                        stop_time,
    input  logic [10:0]                        cur_min,
    input  logic                               sys_enable,
    output logic [NUM_ZONES-1:0]               valve,
    output logic                               loading,
    output logic                               loaded,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   entry_count,
    output logic [7:0]                         err_count,
    output logic                               timeout
);

    localparam int CW = $clog2(NUM_ENTRIES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t         state, state_nxt;
    entry_t         table_q [NUM_ENTRIES];
    logic [15:0]    zone_q;
    logic [31:0]    start_q;
    logic [31:0]    stop_q;
    logic [TW-1:0]  tmo_cnt;

    logic [10:0]    start_min, stop_min;
    logic           start_ok, stop_ok;
    logic [6:0]     zone_num;
    logic           zone_ok, line_ok, is_term;
    logic           clear, store, reject, req_timeout;
    logic [NUM_ZONES-1:0] zone_hit, valve_nxt;

    hhmm_to_min u_start (.hhmm(start_q), .minutes(start_min), .valid(start_ok));
    hhmm_to_min u_stop  (.hhmm(stop_q),  .minutes(stop_min),  .valid(stop_ok));

    always_comb begin
        zone_num = 7'(digit_val(zone_q[15:8])) * 7'd10 + 7'(digit_val(zone_q[7:0]));
        zone_ok  = is_digit(zone_q[15:8]) && is_digit(zone_q[7:0]) &&
                   (zone_num >= 7'd1) && (zone_num <= 7'(NUM_ZONES));
        line_ok  = zone_ok && start_ok && stop_ok;
        is_term  = (zone_q == ZONE_TERMINATOR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        clear       = 1'b0;
        store       = 1'b0;
        reject      = 1'b0;
        req_timeout = 1'b0;
        case (state)
            ST_IDLE, ST_RUN: begin
                if (start_load) begin
                    clear     = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (read_enable) begin
                    state_nxt = ST_WAIT_LO;
                end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    req_timeout = 1'b1;
                    state_nxt   = ST_RUN;
                end
            end
            ST_WAIT_LO: begin
                if (!read_enable) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_term) begin
                    state_nxt = ST_RUN;
                end else if (line_ok) begin
                    store     = 1'b1;
                    state_nxt = (entry_count == CW'(NUM_ENTRIES - 1)) ? ST_RUN : ST_REQ;
                end else begin
                    reject    = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign read_next_line = (state == ST_REQ);
    assign loading        = (state == ST_REQ) || (state == ST_WAIT_LO) || (state == ST_DECODE);
    assign loaded         = (state == ST_RUN);

    function automatic logic entry_active(input entry_t e, input logic [10:0] m);
        if (!e.valid)                  return 1'b0;
        if (e.start_min < e.stop_min)  return (m >= e.start_min) && (m < e.stop_min);
        if (e.start_min > e.stop_min)  return (m >= e.start_min) || (m < e.stop_min);
        return 1'b0;
    endfunction

    always_comb begin
        zone_hit = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int z = 0; z < NUM_ZONES; z++) begin
                if (entry_active(table_q[i], cur_min) && (table_q[i].zone == 4'(z + 1)))
                    zone_hit[z] = 1'b1;
            end
        end
        // start_load in RUN drops the valves on the same edge the load begins
        valve_nxt = '0;
        if (loaded && !start_load && sys_enable && (cur_min < 11'(MIN_PER_DAY)))
            valve_nxt = zone_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zone_q      <= '0;
            start_q     <= '0;
            stop_q      <= '0;
            tmo_cnt     <= '0;
            entry_count <= '0;
            err_count   <= '0;
            timeout     <= 1'b0;
            valve       <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) table_q[i] <= '0;
        end else begin
            valve <= valve_nxt;

            if (state == ST_REQ) tmo_cnt <= tmo_cnt + TW'(1);
            else                 tmo_cnt <= '0;

            if ((state == ST_REQ) && read_enable) begin
                zone_q  <= zone;
                start_q <= start_time;
                stop_q  <= stop_time;
            end

            if (clear) begin
                entry_count <= '0;
                err_count   <= '0;
                timeout     <= 1'b0;
                for (int i = 0; i < NUM_ENTRIES; i++) table_q[i] <= '0;
            end

            if (store) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (entry_count == CW'(i)) begin
                        table_q[i].zone      <= 4'(zone_num);
                        table_q[i].start_min <= start_min;
                        table_q[i].stop_min  <= stop_min;
                        table_q[i].valid     <= 1'b1;
                    end
                end
                entry_count <= entry_count + CW'(1);
            end

            if (reject && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

            if (req_timeout) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sprinkler_scheduler.sv
// tb/tb_sprinkler_scheduler.sv - self-checking bench with directed vectors and a random schedule model
module tb_sprinkler_scheduler;

    localparam int NE  = 8;
    localparam int NZ  = 8;
    localparam int TMO = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_load = 1'b0;
    logic          read_enable = 1'b0;
    logic          sys_enable = 1'b0;
    logic [15:0]   zone = '0;
    logic [31:0]   start_time = '0;
    logic [31:0]   stop_time = '0;
    logic [10:0]   cur_min = '0;
    logic          read_next_line;
    logic [NZ-1:0] valve;
    logic          loading, loaded, timeout;
    logic [3:0]    entry_count;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprinkler_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start_load(start_load),
        .read_next_line(read_next_line), .read_enable(read_enable),
        .zone(zone), .start_time(start_time), .stop_time(stop_time),
        .cur_min(cur_min), .sys_enable(sys_enable), .valve(valve),
        .loading(loading), .loaded(loaded), .entry_count(entry_count),
        .err_count(err_count), .timeout(timeout)
    );

    typedef struct { logic [15:0] z; logic [31:0] st; logic [31:0] sp; } line_t;
    typedef struct { int zone; int smin; int emin; } ment_t;
    typedef struct { int cur; bit se; logic [7:0] exp; } vec_t;

    line_t lines[$];
    ment_t mtab[$];
    int    m_err;
    bit    m_tmo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] a2(input int v);
        return {8'(48 + v / 10), 8'(48 + v % 10)};
    endfunction

    function automatic logic [31:0] a4(input int hh, input int mm);
        return {a2(hh), a2(mm)};
    endfunction

    function automatic line_t mk(input int z, input int sh, input int sm, input int eh, input int em);
        line_t l;
        l.z = a2(z); l.st = a4(sh, sm); l.sp = a4(eh, em);
        return l;
    endfunction

    function automatic int two(input logic [15:0] s);
        int a, b;
        a = (s[15:8] >= 8'h30 && s[15:8] <= 8'h39) ? int'(s[15:8]) - 48 : -1;
        b = (s[7:0]  >= 8'h30 && s[7:0]  <= 8'h39) ? int'(s[7:0])  - 48 : -1;
        if (a < 0 || b < 0) return -1;
        return a * 10 + b;
    endfunction

    function automatic void model_load();
        mtab.delete();
        m_err = 0;
        m_tmo = 1;
        foreach (lines[i]) begin
            int z, sh, sm, eh, em;
            if (lines[i].z == 16'h3030) begin m_tmo = 0; break; end
            z  = two(lines[i].z);
            sh = two(lines[i].st[31:16]); sm = two(lines[i].st[15:0]);
            eh = two(lines[i].sp[31:16]); em = two(lines[i].sp[15:0]);
            if (z >= 1 && z <= NZ && sh >= 0 && sh <= 23 && sm >= 0 && sm <= 59 &&
                eh >= 0 && eh <= 23 && em >= 0 && em <= 59)
                mtab.push_back('{z, sh * 60 + sm, eh * 60 + em});
            else if (m_err < 255)
                m_err++;
            if (mtab.size() == NE) begin m_tmo = 0; break; end
        end
    endfunction

    function automatic logic [7:0] model_valve(input int m, input bit se);
        logic [7:0] v;
        v = '0;
        if (!se || m >= 1440) return v;
        foreach (mtab[i]) begin
            int s, e;
            bit on;
            s = mtab[i].smin; e = mtab[i].emin;
            if (s < e)      on = (m >= s) && (m < e);
            else if (s > e) on = !((m >= e) && (m < s));
            else            on = 0;
            if (on) v[mtab[i].zone - 1] = 1'b1;
        end
        return v;
    endfunction

    function automatic line_t rand_line();
        line_t l;
        int k, p;
        logic [7:0] bad [3];
        bad[0] = 8'h2F; bad[1] = 8'h3A; bad[2] = 8'h41;
        k = $urandom_range(0, 9);
        l = mk($urandom_range(1, NZ), $urandom_range(0, 23), $urandom_range(0, 59),
               $urandom_range(0, 23), $urandom_range(0, 59));
        case (k)
            5: l.sp = l.st;
            6: l.z  = a2($urandom_range(NZ + 1, 99));
            7: l.st = a4($urandom_range(24, 99), $urandom_range(0, 59));
            8: l.sp = a4($urandom_range(0, 23), $urandom_range(60, 99));
            9: begin
                p = $urandom_range(0, 3);
                l.sp[p * 8 +: 8] = bad[$urandom_range(0, 2)];
            end
            default: ;
        endcase
        return l;
    endfunction

    task automatic do_load(output int nreq);
        int idx;
        idx  = 0;
        nreq = 0;
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        chk("load_valve_clear", valve, 0);
        for (int cyc = 0; cyc < 3000 && !loaded; cyc++) begin
            if (read_next_line && idx < lines.size()) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                zone = lines[idx].z; start_time = lines[idx].st; stop_time = lines[idx].sp;
                read_enable = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                read_enable = 1'b0;
                zone = 16'h3131; start_time = $urandom; stop_time = $urandom;
                idx++;
                nreq++;
            end
            @(negedge clk);
        end
        chk("load_done", loaded, 1);
    endtask

    task automatic check_valve(input string name, input int m, input bit se);
        cur_min = 11'(m);
        sys_enable = se;
        @(negedge clk);
        chk(name, valve, model_valve(m, se));
    endtask

    initial begin
        vec_t  vt[14];
        line_t l;
        int    nreq, n, m;
        bit    se;

        vt[0]  = '{360,  1'b1, 8'h01}; vt[1]  = '{389,  1'b1, 8'h01};
        vt[2]  = '{390,  1'b1, 8'h00}; vt[3]  = '{359,  1'b1, 8'h00};
        vt[4]  = '{1410, 1'b1, 8'h04}; vt[5]  = '{1420, 1'b1, 8'h04};
        vt[6]  = '{5,    1'b1, 8'h04}; vt[7]  = '{14,   1'b1, 8'h04};
        vt[8]  = '{15,   1'b1, 8'h00}; vt[9]  = '{1409, 1'b1, 8'h00};
        vt[10] = '{1440, 1'b1, 8'h00}; vt[11] = '{370,  1'b0, 8'h00};
        vt[12] = '{0,    1'b1, 8'h04}; vt[13] = '{360,  1'b1, 8'h01};

        repeat (3) @(negedge clk);
        chk("rst_rnl", read_next_line, 0);
        chk("rst_valve", valve, 0);
        chk("rst_loading", loading, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_entries", entry_count, 0);
        chk("rst_errs", err_count, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        cur_min = 11'd360; sys_enable = 1'b1;
        @(negedge clk);
        chk("idle_valve", valve, 0);

        // two windows, one crossing midnight
        lines.delete();
        lines.push_back(mk(1, 6, 0, 6, 30));
        lines.push_back(mk(3, 23, 30, 0, 15));
        lines.push_back(mk(0, 0, 0, 0, 0));
        do_load(nreq);
        chk("tbl_entries", entry_count, 2);
        chk("tbl_errs", err_count, 0);
        chk("tbl_timeout", timeout, 0);
        chk("tbl_loading", loading, 0);
        foreach (vt[i]) begin
            cur_min = 11'(vt[i].cur);
            sys_enable = vt[i].se;
            @(negedge clk);
            chk($sformatf("vec%0d_min%0d", i, vt[i].cur), valve, vt[i].exp);
        end

        // rejected lines; reload from RUN with a valve on
        lines.delete();
        lines.push_back(mk(2, 25, 60, 1, 0));
        l = mk(1, 1, 0, 2, 0); l.z = 16'h3041; lines.push_back(l);
        lines.push_back(mk(9, 1, 0, 2, 0));
        lines.push_back(mk(0, 0, 0, 0, 0));
        do_load(nreq);
        chk("err_count3", err_count, 3);
        chk("err_entries", entry_count, 0);
        foreach (vt[i]) begin
            cur_min = 11'(vt[i].cur);
            sys_enable = 1'b1;
            @(negedge clk);
            chk("err_valve", valve, 0);
        end

        // ten valid lines, no terminator: table fills after eight
        lines.delete();
        for (int i = 0; i < 10; i++) lines.push_back(mk(i % 8 + 1, 1 + i, 0, 2 + i, 0));
        do_load(nreq);
        model_load();
        chk("full_requests", nreq, 8);
        chk("full_entries", entry_count, 8);
        chk("full_timeout", timeout, 0);
        repeat (3) @(negedge clk);
        chk("full_rnl_low", read_next_line, 0);
        check_valve("full_v90", 90, 1);
        check_valve("full_v150", 150, 1);
        check_valve("full_v540", 540, 1);

        // no response at all: timeout
        lines.delete();
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        n = 0;
        while (!timeout && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < TMO - 1 || n > TMO + 1) begin
            errors++;
            $display("FAIL tmo_cycles: got %0d expected %0d", n, TMO);
        end
        chk("tmo_flag", timeout, 1);
        chk("tmo_loaded", loaded, 1);
        chk("tmo_entries", entry_count, 0);
        chk("tmo_rnl", read_next_line, 0);

        // random schedules against the model
        for (int it = 0; it < 30; it++) begin
            lines.delete();
            n = $urandom_range(0, 10);
            repeat (n) lines.push_back(rand_line());
            lines.push_back(mk(0, 0, 0, 0, 0));
            do_load(nreq);
            model_load();
            chk("rnd_entries", entry_count, mtab.size());
            chk("rnd_errs", err_count, m_err);
            chk("rnd_timeout", timeout, m_tmo);
            for (int k = 0; k < 6; k++) begin
                if (mtab.size() > 0 && $urandom_range(0, 1) == 1) begin
                    ment_t e;
                    e = mtab[$urandom_range(0, mtab.size() - 1)];
                    case ($urandom_range(0, 3))
                        0: m = e.smin;
                        1: m = e.emin;
                        2: m = (e.smin + 1439) % 1440;
                        default: m = (e.emin + 1439) % 1440;
                    endcase
                end else begin
                    m = $urandom_range(0, 1535);
                end
                se = ($urandom_range(0, 5) != 0);
                check_valve($sformatf("rnd%0d_min%0d_se%0d", it, m, se), m, se);
            end
        end

        // reset pulled while waiting for read_enable to fall
        cur_min = 11'd360; sys_enable = 1'b1;
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        l = mk(1, 6, 0, 6, 30);
        zone = l.z; start_time = l.st; stop_time = l.sp; read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_entries_pre", entry_count, 1);
        chk("mid_rnl_pre", read_next_line, 1);
        l = mk(2, 7, 0, 8, 0);
        zone = l.z; start_time = l.st; stop_time = l.sp; read_enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_waitlo_loading", loading, 1);
        chk("mid_waitlo_rnl", read_next_line, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rnl", read_next_line, 0);
        chk("mid_rst_valve", valve, 0);
        chk("mid_rst_entries", entry_count, 0);
        chk("mid_rst_loading", loading, 0);
        @(negedge clk);
        read_enable = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valve", valve, 0);
        chk("post_rst_loaded", loaded, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
